// File: rtl/fetch_pc_control_if.sv
// Instruction-memory read bus between the fetch stage (master) and imem (slave).
// A request is held (rd_en + addr stable) until the cycle imem_ack_in is high.
interface fetch_pc_control_if #(
    parameter int PC_WIDTH          = 32,
    parameter int INSTRUCTION_WIDTH = 32
);
    logic                         imem_rd_en_out;
    logic [PC_WIDTH-1:0]          imem_addr_out;
    logic                         imem_ack_in;
    logic [INSTRUCTION_WIDTH-1:0] imem_data_in;

    modport master (
        output imem_rd_en_out, imem_addr_out,
        input  imem_ack_in, imem_data_in
    );

    modport slave (
        input  imem_rd_en_out, imem_addr_out,
        output imem_ack_in, imem_data_in
    );
endinterface

// File: rtl/fetch_pc_control.sv
// Fetch-stage PC owner. Issues word reads over the imem bus, delivers
// {instruction, pc, pc+4} to IF/ID, parks one ack in a skid buffer while the
// downstream is stalled, and squashes in-flight fetches on an execute redirect.
// Optional feature macro: UDLX_FETCH_PERF_CNT_EN (redirect and stall counters).
module fetch_pc_control #(
    parameter int                  PC_WIDTH          = 32,
    parameter int                  INSTRUCTION_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC          = '0,
    parameter int                  PERF_CNT_WIDTH    = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         stall_in,
    input  logic                         select_new_pc_in,
    input  logic [PC_WIDTH-1:0]          new_pc_in,
    fetch_pc_control_if.master           imem,
    output logic [INSTRUCTION_WIDTH-1:0] instruction_out,
    output logic                         instruction_valid_out,
    output logic [PC_WIDTH-1:0]          pc_out,
    output logic [PC_WIDTH-1:0]          new_pc_out,
    output logic [PERF_CNT_WIDTH-1:0]    redirect_count_out,
    output logic [PERF_CNT_WIDTH-1:0]    stall_count_out
);
    typedef enum logic [1:0] {BOOT, REQ, HOLD, DRAIN} state_e;

    state_e                         state_q, state_d;
    logic [PC_WIDTH-1:0]            pc_q, pc_d;
    logic                           rd_en_q, rd_en_d;
    logic [INSTRUCTION_WIDTH-1:0]   instr_q, instr_d;
    logic                           valid_q, valid_d;
    logic [PC_WIDTH-1:0]            pc_out_q, pc_out_d;
    logic [PC_WIDTH-1:0]            npc_out_q, npc_out_d;
    logic [INSTRUCTION_WIDTH-1:0]   skid_instr_q, skid_instr_d;
    logic [PC_WIDTH-1:0]            skid_pc_q, skid_pc_d;
    logic [PC_WIDTH-1:0]            skid_npc_q, skid_npc_d;
    logic [PC_WIDTH-1:0]            pc_plus4;
    logic [PC_WIDTH-1:0]            redirect_pc;

    // PC+4 wraps naturally at the top of the address space
    assign pc_plus4    = pc_q + PC_WIDTH'(4);
    // Redirect targets are forced to word alignment
    assign redirect_pc = new_pc_in & ~PC_WIDTH'(3);

    // Next-state: fetch sequencing, skid capture, redirect squash (redirect wins)
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        valid_d      = valid_q;
        pc_out_d     = pc_out_q;
        npc_out_d    = npc_out_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_npc_d   = skid_npc_q;
        // Nothing delivered this cycle: drop valid unless downstream is frozen
        if (!stall_in) valid_d = 1'b0;
        case (state_q)
            BOOT: state_d = REQ;  // any ack seen here is stale and ignored
            REQ: begin
                if (imem.imem_ack_in) begin
                    pc_d = pc_plus4;
                    if (!stall_in) begin
                        instr_d   = imem.imem_data_in;
                        pc_out_d  = pc_q;
                        npc_out_d = pc_plus4;
                        valid_d   = 1'b1;
                    end else begin
                        skid_instr_d = imem.imem_data_in;
                        skid_pc_d    = pc_q;
                        skid_npc_d   = pc_plus4;
                        state_d      = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!stall_in) begin
                    instr_d   = skid_instr_q;
                    pc_out_d  = skid_pc_q;
                    npc_out_d = skid_npc_q;
                    valid_d   = 1'b1;
                    state_d   = REQ;
                end
            end
            DRAIN: if (imem.imem_ack_in) state_d = REQ;  // discard the squashed data
            default: state_d = BOOT;
        endcase
        if (select_new_pc_in) begin
            pc_d         = redirect_pc;
            valid_d      = 1'b0;
            skid_instr_d = '0;
            skid_pc_d    = '0;
            skid_npc_d   = '0;
            // Only an unacked request leaves something in flight to drain.
            // A redirect in DRAIN that coincides with the ack has nothing left
            // to wait for, so it goes straight to REQ instead of hanging.
            case (state_q)
                REQ, DRAIN: state_d = imem.imem_ack_in ? REQ : DRAIN;
                default:    state_d = REQ;
            endcase
        end
        rd_en_d = (state_d == REQ);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            rd_en_q      <= 1'b0;
            instr_q      <= '0;
            valid_q      <= 1'b0;
            pc_out_q     <= '0;
            npc_out_q    <= '0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            skid_npc_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            rd_en_q      <= rd_en_d;
            instr_q      <= instr_d;
            valid_q      <= valid_d;
            pc_out_q     <= pc_out_d;
            npc_out_q    <= npc_out_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_npc_q   <= skid_npc_d;
        end
    end

    assign imem.imem_rd_en_out   = rd_en_q;
    assign imem.imem_addr_out    = pc_q;
    assign instruction_out       = instr_q;
    assign instruction_valid_out = valid_q;
    assign pc_out                = pc_out_q;
    assign new_pc_out            = npc_out_q;

`ifdef UDLX_FETCH_PERF_CNT_EN
    logic [PERF_CNT_WIDTH-1:0] redirect_cnt_q, redirect_cnt_d;
    logic [PERF_CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating event counters
    always_comb begin
        redirect_cnt_d = redirect_cnt_q;
        stall_cnt_d    = stall_cnt_q;
        if (select_new_pc_in && (redirect_cnt_q != '1))
            redirect_cnt_d = redirect_cnt_q + PERF_CNT_WIDTH'(1);
        if (stall_in && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + PERF_CNT_WIDTH'(1);
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_cnt_q <= '0;
            stall_cnt_q    <= '0;
        end else begin
            redirect_cnt_q <= redirect_cnt_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    assign redirect_count_out = redirect_cnt_q;
    assign stall_count_out    = stall_cnt_q;
`else
    assign redirect_count_out = '0;
    assign stall_count_out    = '0;
`endif
endmodule

// File: tb/tb_fetch_pc_control.sv
// Directed bench for fetch_pc_control: streaming fetch, stall/skid, redirect
// drain, redirect+ack+stall, PC wrap, mid-transaction reset, perf counters.
module tb_fetch_pc_control;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_in = 1'b0;
    logic        select_new_pc_in = 1'b0;
    logic [31:0] new_pc_in = '0;
    logic [31:0] instruction_out, pc_out, new_pc_out;
    logic        instruction_valid_out;
    logic [15:0] redirect_count_out, stall_count_out;

    int n_assert = 0;
    int n_fail   = 0;

`ifdef UDLX_FETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    fetch_pc_control_if #(.PC_WIDTH(32), .INSTRUCTION_WIDTH(32)) bus ();

    fetch_pc_control #(
        .PC_WIDTH(32), .INSTRUCTION_WIDTH(32), .RESET_PC(32'h0), .PERF_CNT_WIDTH(16)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .stall_in              (stall_in),
        .select_new_pc_in      (select_new_pc_in),
        .new_pc_in             (new_pc_in),
        .imem                  (bus),
        .instruction_out       (instruction_out),
        .instruction_valid_out (instruction_valid_out),
        .pc_out                (pc_out),
        .new_pc_out            (new_pc_out),
        .redirect_count_out    (redirect_count_out),
        .stall_count_out       (stall_count_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ack(input logic on, input logic [31:0] a);
        bus.imem_ack_in  = on;
        bus.imem_data_in = mem_word(a);
    endtask

    task automatic perf(input string tag, input int stalls, input int redirs);
        check({tag, "_stall_cnt"}, {16'h0, stall_count_out},    PERF ? stalls : 0);
        check({tag, "_redir_cnt"}, {16'h0, redirect_count_out}, PERF ? redirs : 0);
    endtask

    initial begin
        bus.imem_ack_in  = 1'b0;
        bus.imem_data_in = '0;
        tick(); tick();

        // Reset state
        check("rst_rd_en", {31'h0, bus.imem_rd_en_out}, 32'h0);
        check("rst_addr",  bus.imem_addr_out, 32'h0);
        check("rst_valid", {31'h0, instruction_valid_out}, 32'h0);
        check("rst_instr", instruction_out, 32'h0);
        check("rst_pc",    pc_out, 32'h0);
        check("rst_npc",   new_pc_out, 32'h0);
        perf("rst", 0, 0);

        // 1: streaming fetch with ack on every REQ cycle
        rst_n = 1'b1;
        check("boot_rd_en", {31'h0, bus.imem_rd_en_out}, 32'h0);
        tick();
        check("req_rd_en", {31'h0, bus.imem_rd_en_out}, 32'h1);
        check("req_addr0", bus.imem_addr_out, 32'h0);
        for (int i = 0; i < 4; i++) begin
            ack(1'b1, 32'(4 * i));
            tick();
            check("s1_valid", {31'h0, instruction_valid_out}, 32'h1);
            check("s1_pc",    pc_out, 32'(4 * i));
            check("s1_npc",   new_pc_out, 32'(4 * i + 4));
            check("s1_instr", instruction_out, mem_word(32'(4 * i)));
        end
        check("s1_addr", bus.imem_addr_out, 32'h10);

        // 2: ack for 0x10 under a 3-cycle stall goes to the skid buffer
        stall_in = 1'b1;
        ack(1'b1, 32'h10);
        tick();
        ack(1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            check("s2_hold_pc",    pc_out, 32'hC);
            check("s2_hold_valid", {31'h0, instruction_valid_out}, 32'h1);
            check("s2_rd_en",      {31'h0, bus.imem_rd_en_out}, 32'h0);
            tick();
        end
        check("s2_hold_pc3", pc_out, 32'hC);
        stall_in = 1'b0;
        tick();
        check("s2_skid_valid", {31'h0, instruction_valid_out}, 32'h1);
        check("s2_skid_pc",    pc_out, 32'h10);
        check("s2_skid_instr", instruction_out, mem_word(32'h10));
        check("s2_next_addr",  bus.imem_addr_out, 32'h14);
        check("s2_rd_en_back", {31'h0, bus.imem_rd_en_out}, 32'h1);
        perf("s2", 3, 0);

        // 3: redirect to 0x200 while the 0x40 request is unacked
        for (int a = 32'h14; a < 32'h40; a += 4) begin
            ack(1'b1, 32'(a));
            tick();
        end
        ack(1'b0, 32'h0);
        tick();
        check("s3_addr40", bus.imem_addr_out, 32'h40);
        check("s3_idle_valid", {31'h0, instruction_valid_out}, 32'h0);
        select_new_pc_in = 1'b1;
        new_pc_in        = 32'h200;
        tick();
        select_new_pc_in = 1'b0;
        check("s3_drain_rd_en", {31'h0, bus.imem_rd_en_out}, 32'h0);
        tick();
        check("s3_drain_wait", {31'h0, bus.imem_rd_en_out}, 32'h0);
        ack(1'b1, 32'h40);
        tick();
        check("s3_discard_valid", {31'h0, instruction_valid_out}, 32'h0);
        check("s3_new_addr", bus.imem_addr_out, 32'h200);
        check("s3_new_rd_en", {31'h0, bus.imem_rd_en_out}, 32'h1);
        ack(1'b1, 32'h200);
        tick();
        check("s3_valid200", {31'h0, instruction_valid_out}, 32'h1);
        check("s3_pc200",    pc_out, 32'h200);
        check("s3_instr200", instruction_out, mem_word(32'h200));

        // 4: redirect to 0x103 with ack and stall in the same cycle
        ack(1'b1, 32'h204);
        stall_in         = 1'b1;
        select_new_pc_in = 1'b1;
        new_pc_in        = 32'h103;
        tick();
        stall_in         = 1'b0;
        select_new_pc_in = 1'b0;
        check("s4_valid", {31'h0, instruction_valid_out}, 32'h0);
        check("s4_addr",  bus.imem_addr_out, 32'h100);
        check("s4_rd_en", {31'h0, bus.imem_rd_en_out}, 32'h1);

        // 5: PC wrap at the top of the address space
        ack(1'b1, 32'h100);
        select_new_pc_in = 1'b1;
        new_pc_in        = 32'hFFFF_FFFC;
        tick();
        select_new_pc_in = 1'b0;
        check("s5_addr_top", bus.imem_addr_out, 32'hFFFF_FFFC);
        ack(1'b1, 32'hFFFF_FFFC);
        tick();
        check("s5_valid", {31'h0, instruction_valid_out}, 32'h1);
        check("s5_pc",    pc_out, 32'hFFFF_FFFC);
        check("s5_npc",   new_pc_out, 32'h0);
        check("s5_addr",  bus.imem_addr_out, 32'h0);
        perf("s5", 4, 3);

        // Reset mid-transaction; an ack seen in BOOT is ignored
        rst_n = 1'b0;
        tick();
        check("mr_valid", {31'h0, instruction_valid_out}, 32'h0);
        check("mr_addr",  bus.imem_addr_out, 32'h0);
        perf("mr", 0, 0);
        rst_n            = 1'b1;
        bus.imem_ack_in  = 1'b1;
        bus.imem_data_in = 32'hDEAD_BEEF;
        tick();
        check("mr_boot_valid", {31'h0, instruction_valid_out}, 32'h0);
        check("mr_boot_rd_en", {31'h0, bus.imem_rd_en_out}, 32'h1);
        ack(1'b1, 32'h0);
        tick();
        check("mr_first_valid", {31'h0, instruction_valid_out}, 32'h1);
        check("mr_first_instr", instruction_out, mem_word(32'h0));
        check("mr_first_pc",    pc_out, 32'h0);
        ack(1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
